track_overlay_ctrl: RTL
=======================

Name: track_overlay_ctrl

Overview:
- Frame-synchronous controller that sits between the object-measurement stage and the overlay/colouring stage.
- Qualifies per-frame centroid results and updates the object centre (x_obj/y_obj) only at frame boundaries, so the overlay never tears mid-frame.
- Gates the overlay enable through an acquire/track/coast/lost state machine driven by consecutive hit or miss frames.

Parameters:
DISP_WIDTH, 11, width of the coordinate buses
COUNT_WIDTH, 20, width of the measured object pixel count
MIN_PIXELS, 64, minimum pixel count for a measurement to qualify as a hit
LOST_FRAMES, 4, consecutive missed frames before a lock is dropped (legal range 1..15)
SMOOTH_SHIFT, 2, exponential smoothing shift; used only with TRACK_SMOOTH_EN

Ports:
clk  in  1  system clock
aresetn  in  1  asynchronous, active-low reset
sw_enable  in  1  user tracking enable (level)
frame_start  in  1  single-cycle pulse at the start of each frame (vsync edge)
meas_valid  in  1  single-cycle pulse: the meas_* inputs are valid
meas_x  in  DISP_WIDTH  measured centroid x
meas_y  in  DISP_WIDTH  measured centroid y
meas_count  in  COUNT_WIDTH  object pixel count for the measurement
x_obj  out  DISP_WIDTH  object centre x for the overlay
y_obj  out  DISP_WIDTH  object centre y for the overlay
overlay_en  out  1  enable for the overlay/colouring stage
locked  out  1  1 only in the TRACK state
lost_pulse  out  1  one-cycle pulse when a lock is dropped

Behaviour:
- Reset values:
  - state = IDLE.
  - x_obj = y_obj = 0.
  - overlay_en, locked, lost_pulse = 0.
  - Pending registers and miss_cnt cleared.
  - Reset mid-frame discards any pending measurement.
- Qualification:
  - A hit requires meas_valid=1 and meas_count >= MIN_PIXELS (unsigned compare).
  - On a hit: pend_x/pend_y <= meas_x/meas_y and pend_hit <= 1.
  - Multiple hits in one frame: the last one wins.
  - A non-qualifying meas_valid is ignored and does not clear pend_hit.
- Simultaneous meas_valid and frame_start: the measurement belongs to the ending frame and is used by that frame's update through a bypass path.
- frame_start update (all outputs registered; visible the cycle after frame_start):
  - IDLE: no action.
  - ACQUIRE:
    - hit -> load x/y, go to TRACK, miss_cnt=0.
    - miss -> stay in ACQUIRE.
  - TRACK:
    - hit -> update x/y, miss_cnt=0.
    - miss -> go to HOLD, miss_cnt=1, x/y held.
  - HOLD:
    - hit -> update x/y, go to TRACK, miss_cnt=0.
    - miss -> miss_cnt+1; if the new miss_cnt >= LOST_FRAMES, go to ACQUIRE with lost_pulse=1 for one cycle.
  - LOST_FRAMES=1 means TRACK goes directly to ACQUIRE on the first miss, with lost_pulse.
  - pend_hit is cleared on every frame_start, after use.
- Output decode:
  - overlay_en = 1 in TRACK or HOLD (registered).
  - locked = 1 in TRACK.
  - x_obj/y_obj retain their last value in every other state.
- sw_enable:
  - sw_enable=0 -> IDLE on the next clk, regardless of frame position; overlay_en=0 the same cycle the state changes; pending cleared; x/y retained.
  - 0->1 -> ACQUIRE on the next clk.
  - frame_start in the same cycle as sw_enable=0 -> disable wins.
- Coordinates are passed through unmodified (no clamping) when smoothing is off.

Optional Feature:
- Macro: TRACK_SMOOTH_EN.
- Defined:
  - In TRACK/HOLD on a hit: x_obj <= x_obj + ((pend_x - x_obj) >>> SMOOTH_SHIFT), using signed DISP_WIDTH+1 arithmetic with an arithmetic shift, truncated back to DISP_WIDTH. y_obj is updated the same way.
  - The first lock out of ACQUIRE loads the measurement directly (no smoothing).
- Undefined: x_obj/y_obj load the raw qualified measurement; no SMOOTH_SHIFT logic is synthesised.

Test Plan:
- Reset, then sw_enable=1, meas_valid with (100,200) and count=64, then frame_start -> next cycle x_obj=100, y_obj=200, overlay_en=1, locked=1.
- In TRACK with LOST_FRAMES=4, send 4 frame_starts with no hits -> HOLD after frame 1 (overlay_en=1, locked=0); after frame 4 state=ACQUIRE, overlay_en=0, lost_pulse high for exactly 1 cycle; x/y retain (100,200).
- Send meas_valid with count=63 at (5,5), then frame_start -> no lock; overlay_en stays 0.
- Send meas_valid at (300,40) in the same cycle as frame_start while in ACQUIRE -> lock, x_obj=300, y_obj=40.
- Deassert sw_enable mid-frame while in TRACK -> overlay_en=0 next cycle; later frame_start with a pending hit -> no update.
- With TRACK_SMOOTH_EN and SMOOTH_SHIFT=2: locked at (100,100), then hit (20,180) -> x_obj=80, y_obj=120.

Source files
------------

// File: rtl/track_overlay_ctrl.sv
// track_overlay_ctrl: qualifies per-frame centroids and gates the overlay through an acquire/track/hold lock FSM.
// Optional macro TRACK_SMOOTH_EN: exponential smoothing of the tracked centre while locked.
module track_overlay_ctrl #(
  parameter int DISP_WIDTH   = 11,
  parameter int COUNT_WIDTH  = 20,
  parameter int MIN_PIXELS   = 64,
  parameter int LOST_FRAMES  = 4,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   sw_enable,
  input  logic                   frame_start,
  input  logic                   meas_valid,
  input  logic [DISP_WIDTH-1:0]  meas_x,
  input  logic [DISP_WIDTH-1:0]  meas_y,
  input  logic [COUNT_WIDTH-1:0] meas_count,
  output logic [DISP_WIDTH-1:0]  x_obj,
  output logic [DISP_WIDTH-1:0]  y_obj,
  output logic                   overlay_en,
  output logic                   locked,
  output logic                   lost_pulse
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, HOLD} state_t;
  state_t r_state, w_state_nxt;
  logic [DISP_WIDTH-1:0] r_pend_x, r_pend_y, r_x, r_y;
  logic [DISP_WIDTH-1:0] w_x_nxt, w_y_nxt, w_sel_x, w_sel_y, w_trk_x, w_trk_y;
  logic r_pend_hit, w_meas_hit, w_frame_hit, w_lost_nxt;
  logic [3:0] r_miss_cnt, w_miss_nxt, w_miss_inc;
  logic r_overlay_en, r_locked, r_lost_pulse;

  assign w_meas_hit  = meas_valid && (meas_count >= COUNT_WIDTH'(MIN_PIXELS));
  // A measurement coinciding with frame_start belongs to the ending frame.
  assign w_frame_hit = w_meas_hit || r_pend_hit;
  assign w_sel_x     = w_meas_hit ? meas_x : r_pend_x;
  assign w_sel_y     = w_meas_hit ? meas_y : r_pend_y;

`ifdef TRACK_SMOOTH_EN
  function automatic logic [DISP_WIDTH-1:0] smooth(input logic [DISP_WIDTH-1:0] cur, input logic [DISP_WIDTH-1:0] tgt);
    logic signed [DISP_WIDTH:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    d = d >>> SMOOTH_SHIFT;
    return cur + d[DISP_WIDTH-1:0];
  endfunction
  assign w_trk_x = smooth(r_x, w_sel_x);
  assign w_trk_y = smooth(r_y, w_sel_y);
`else
  assign w_trk_x = w_sel_x;
  assign w_trk_y = w_sel_y;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_miss_nxt  = r_miss_cnt;
    w_lost_nxt  = 1'b0;
    w_miss_inc  = (r_state == TRACK ? 4'd0 : r_miss_cnt) + 4'd1;
    if (!sw_enable) begin
      w_state_nxt = IDLE;
      w_miss_nxt  = 4'd0;
    end else if (r_state == IDLE) begin
      w_state_nxt = ACQUIRE;
    end else if (frame_start) begin
      if (w_frame_hit) begin
        w_state_nxt = TRACK;
        w_miss_nxt  = 4'd0;
        w_x_nxt     = r_state == ACQUIRE ? w_sel_x : w_trk_x;
        w_y_nxt     = r_state == ACQUIRE ? w_sel_y : w_trk_y;
      end else if (r_state != ACQUIRE) begin
        w_state_nxt = w_miss_inc >= 4'(LOST_FRAMES) ? ACQUIRE : HOLD;
        w_lost_nxt  = w_miss_inc >= 4'(LOST_FRAMES);
        w_miss_nxt  = w_miss_inc >= 4'(LOST_FRAMES) ? 4'd0 : w_miss_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_miss_cnt   <= '0;
      r_overlay_en <= 1'b0;
      r_locked     <= 1'b0;
      r_lost_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_miss_cnt   <= w_miss_nxt;
      r_overlay_en <= (w_state_nxt == TRACK) || (w_state_nxt == HOLD);
      r_locked     <= w_state_nxt == TRACK;
      r_lost_pulse <= w_lost_nxt;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_pend_hit <= 1'b0;
      r_pend_x   <= '0;
      r_pend_y   <= '0;
    end else if (!sw_enable || frame_start) begin
      r_pend_hit <= 1'b0;
    end else if (w_meas_hit) begin
      r_pend_hit <= 1'b1;
      r_pend_x   <= meas_x;
      r_pend_y   <= meas_y;
    end
  end

  assign x_obj      = r_x;
  assign y_obj      = r_y;
  assign overlay_en = r_overlay_en;
  assign locked     = r_locked;
  assign lost_pulse = r_lost_pulse;
endmodule
